sdram_port_arb: RTL and testbench
=================================

Name: sdram_port_arb

Overview:
- Shares one toggle-handshake SDRAM port between two byte-wide requesters: the Oric CPU RAM bus and the FDC sector-buffer DMA.
- Sits between the core/FDC and the sdram controller port in the top level, and replaces the ad-hoc CPU request-toggling logic there.
- Converts single-cycle byte requests into 16-bit word accesses with byte-lane enables.
- Arbitrates with CPU priority and a bounded FDC starvation guard.

Parameters:
- ADDR_W, 24, width of the SDRAM word address.
- CPU_BASE, 24'h000000, word-address base of the CPU 64 KB window.
- FDC_BASE, 24'h010000, word-address base of the FDC buffer window.
- FDC_MAX_WAIT, 4, number of consecutive CPU grants allowed while an FDC request is pending; range 1..15.
- TIMEOUT, 255, cycles to wait for mem_ack before aborting; an 8-bit counter.

Ports:
- clk  in  1  the single clock (the SDRAM-domain clock).
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  one-cycle request strobe.
- cpu_we  in  1  1 = write.
- cpu_a  in  16  CPU byte address.
- cpu_d  in  8  CPU write data.
- cpu_q  out  8  CPU read data; held until the next CPU completion.
- cpu_busy  out  1  a CPU request is pending or in flight.
- fdc_req  in  1  one-cycle request strobe.
- fdc_we  in  1  1 = write.
- fdc_a  in  16  FDC byte address.
- fdc_d  in  8  FDC write data.
- fdc_q  out  8  FDC read data.
- fdc_done  out  1  one-cycle completion pulse.
- fdc_busy  out  1  an FDC request is pending or in flight.
- mem_req  out  1  toggles to issue an access.
- mem_ack  in  1  controller mirrors mem_req when the access completes.
- mem_a  out  ADDR_W  word address.
- mem_ds  out  2  byte enables; [1] = high byte.
- mem_we  out  1  write enable.
- mem_d  out  16  write data.
- mem_q  in  16  read data, valid when mem_ack matches mem_req.
- err  out  1  sticky: overrun or timeout; cleared only by reset.

Behaviour:
- Reset values: mem_req=0, mem_a=0, mem_ds=2'b11, mem_we=0, mem_d=0, cpu_q=0, fdc_q=0, fdc_done=0, cpu_busy=0, fdc_busy=0, err=0, starvation count=0. The state machine enters SYNC.
- Request capture:
  - cpu_req latches we/a/d into the CPU pending slot and sets cpu_busy on the next edge.
  - fdc_req does the same for the FDC slot and fdc_busy.
  - A strobe that arrives while its slot is busy is dropped and sets err.
- Address mapping:
  - mem_a = BASE + a[15:1], zero-extended to ADDR_W.
  - Write: mem_ds = a[0] ? 2'b10 : 2'b01, and mem_d = {d,d}.
  - Read: mem_ds = 2'b11. Returned byte = a[0] ? mem_q[15:8] : mem_q[7:0].
- State machine:
  - SYNC: wait until mem_ack==mem_req, then go to IDLE. This covers a reset in the middle of an operation while the controller is still busy.
  - IDLE, if only one slot is pending: grant that slot.
  - IDLE, if both slots are pending: grant FDC if the starvation count equals FDC_MAX_WAIT; otherwise grant CPU and increment the count.
  - IDLE, after any FDC grant, or when FDC is not pending: clear the count.
  - On a grant: drive mem_a/ds/we/d, toggle mem_req in the same edge, go to WAIT.
  - WAIT, when mem_ack==mem_req: capture the read byte (reads only), clear the granted slot's busy, pulse fdc_done for an FDC grant, return to IDLE.
  - WAIT, timeout: if the counter reaches TIMEOUT first, set err, return 8'hFF as read data, complete the access as above, and go to SYNC.
- Timing and latency:
  - At least one IDLE cycle between grants.
  - Best-case latency is strobe→grant 2 cycles, then controller latency, then 1 cycle to the busy drop.
- Ordering and simultaneity:
  - A strobe in the same cycle as its own slot's completion is accepted: completion takes precedence over the overrun check.
  - Simultaneous CPU and FDC strobes are both captured.
  - mem_* outputs are stable throughout WAIT.

Optional Feature:
- Macro SDRAM_ARB_STATS_EN.
- When defined, adds two outputs, cpu_grants[15:0] and fdc_grants[15:0]. Each is a saturating count of grants issued, incremented on the grant edge and cleared by reset.
- When undefined, those ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- CPU write then read, cpu_a=16'h1235, cpu_d=8'hA5:
  - Write: mem_a=CPU_BASE+0x091A, mem_ds=2'b10, mem_d=16'hA5A5.
  - Read: the model returns 16'hA5xx, so cpu_q=8'hA5 and cpu_busy drops.
- FDC read with fdc_a=16'h0010, model returns 16'h3C7E: mem_a=FDC_BASE+8, fdc_q=8'h7E, fdc_done high for exactly 1 cycle.
- CPU strobe on every free slot plus one FDC strobe, FDC_MAX_WAIT=4: exactly 4 CPU grants, then the FDC grant, then CPU again.
- Second cpu_req while cpu_busy=1: request dropped, err=1, only one mem_req toggle.
- Model never acks:
  - After 255 WAIT cycles, err=1 and cpu_q=8'hFF.
  - The arbiter stays in SYNC until the model toggles mem_ack, then services the queued FDC request.
- Assert reset during WAIT with the model's ack still owed: all outputs return to reset values, and no grant occurs until mem_ack==0.

Source files
------------

// File: rtl/sdram_port_arb.sv
// Shares one toggle-handshake SDRAM word port between the CPU and FDC byte requesters.
// Optional saturating grant counters are built when SDRAM_ARB_STATS_EN is defined.
module sdram_port_arb #(
    parameter int unsigned       ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] CPU_BASE     = 24'h000000,
    parameter logic [ADDR_W-1:0] FDC_BASE     = 24'h010000,
    parameter int unsigned       FDC_MAX_WAIT = 4,
    parameter int unsigned       TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [15:0]       i_cpu_a,
    input  logic [7:0]        i_cpu_d,
    output logic [7:0]        o_cpu_q,
    output logic              o_cpu_busy,
    input  logic              i_fdc_req,
    input  logic              i_fdc_we,
    input  logic [15:0]       i_fdc_a,
    input  logic [7:0]        i_fdc_d,
    output logic [7:0]        o_fdc_q,
    output logic              o_fdc_done,
    output logic              o_fdc_busy,
    output logic              o_mem_req,
    input  logic              i_mem_ack,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic [1:0]        o_mem_ds,
    output logic              o_mem_we,
    output logic [15:0]       o_mem_d,
    input  logic [15:0]       i_mem_q,
    output logic              o_err,
`ifdef SDRAM_ARB_STATS_EN
    output logic [15:0]       o_cpu_grants,
    output logic [15:0]       o_fdc_grants,
`endif
    output logic [1:0]        o_dbg_state
);

    // Handshake: requester strobes are single-cycle and are held in a slot until completion;
    // an access is issued by toggling mem_req and is complete once mem_ack equals mem_req.
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT = 4'(FDC_MAX_WAIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state, w_state_nx;
    logic              r_cpu_busy, r_cpu_we;
    logic [15:0]       r_cpu_a;
    logic [7:0]        r_cpu_d;
    logic              r_fdc_busy, r_fdc_we;
    logic [15:0]       r_fdc_a;
    logic [7:0]        r_fdc_d;
    logic              r_gnt_fdc, r_lane;
    logic [3:0]        r_starve;
    logic [7:0]        r_tmo;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_a;
    logic [1:0]        r_mem_ds;
    logic [15:0]       r_mem_d;
    logic [7:0]        r_cpu_q, r_fdc_q;
    logic              r_fdc_done, r_err;

    logic              w_ack_match, w_grant_cpu, w_grant_fdc, w_grant, w_done, w_tmo;
    logic              w_cpu_done, w_fdc_done, w_cpu_ovr, w_fdc_ovr;
    logic              w_sel_we;
    logic [15:0]       w_sel_a;
    logic [7:0]        w_sel_d, w_rd_byte;
    logic [ADDR_W-1:0] w_sel_base;

    assign w_ack_match = (i_mem_ack == r_mem_req);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_SYNC;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_grant_cpu = 1'b0;
        w_grant_fdc = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_ack_match) w_state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                // CPU wins unless the FDC has already been passed over MAX_WAIT times in a row.
                if (r_cpu_busy && !(r_fdc_busy && r_starve == MAX_WAIT)) w_grant_cpu = 1'b1;
                else if (r_fdc_busy)                                     w_grant_fdc = 1'b1;
                if (w_grant_cpu || w_grant_fdc) w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_ack_match) begin
                    w_done     = 1'b1;
                    w_state_nx = ST_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_done     = 1'b1;
                    w_tmo      = 1'b1;
                    w_state_nx = ST_SYNC;
                end
            end
            default: w_state_nx = ST_SYNC;
        endcase
    end

    assign w_grant    = w_grant_cpu | w_grant_fdc;
    assign w_cpu_done = w_done & ~r_gnt_fdc;
    assign w_fdc_done = w_done & r_gnt_fdc;
    // Completion on the same edge frees the slot, so a back-to-back strobe is not an overrun.
    assign w_cpu_ovr  = i_cpu_req & r_cpu_busy & ~w_cpu_done;
    assign w_fdc_ovr  = i_fdc_req & r_fdc_busy & ~w_fdc_done;

    assign w_sel_we   = w_grant_fdc ? r_fdc_we : r_cpu_we;
    assign w_sel_a    = w_grant_fdc ? r_fdc_a  : r_cpu_a;
    assign w_sel_d    = w_grant_fdc ? r_fdc_d  : r_cpu_d;
    assign w_sel_base = w_grant_fdc ? FDC_BASE : CPU_BASE;
    assign w_rd_byte  = w_tmo ? 8'hFF : (r_lane ? i_mem_q[15:8] : i_mem_q[7:0]);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_busy <= 1'b0;
            r_cpu_we   <= 1'b0;
            r_cpu_a    <= '0;
            r_cpu_d    <= '0;
        end else begin
            if (w_cpu_done) r_cpu_busy <= 1'b0;
            if (i_cpu_req && !w_cpu_ovr) begin
                r_cpu_busy <= 1'b1;
                r_cpu_we   <= i_cpu_we;
                r_cpu_a    <= i_cpu_a;
                r_cpu_d    <= i_cpu_d;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fdc_busy <= 1'b0;
            r_fdc_we   <= 1'b0;
            r_fdc_a    <= '0;
            r_fdc_d    <= '0;
        end else begin
            if (w_fdc_done) r_fdc_busy <= 1'b0;
            if (i_fdc_req && !w_fdc_ovr) begin
                r_fdc_busy <= 1'b1;
                r_fdc_we   <= i_fdc_we;
                r_fdc_a    <= i_fdc_a;
                r_fdc_d    <= i_fdc_d;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mem_req <= 1'b0;
            r_mem_a   <= '0;
            r_mem_ds  <= 2'b11;
            r_mem_we  <= 1'b0;
            r_mem_d   <= '0;
            r_gnt_fdc <= 1'b0;
            r_lane    <= 1'b0;
        end else if (w_grant) begin
            r_mem_req <= ~r_mem_req;
            r_mem_a   <= w_sel_base + ADDR_W'(w_sel_a[15:1]);
            r_mem_ds  <= w_sel_we ? (w_sel_a[0] ? 2'b10 : 2'b01) : 2'b11;
            r_mem_we  <= w_sel_we;
            r_mem_d   <= {w_sel_d, w_sel_d};
            r_gnt_fdc <= w_grant_fdc;
            r_lane    <= w_sel_a[0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve <= '0;
            r_tmo    <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_grant_cpu && r_fdc_busy) r_starve <= r_starve + 4'd1;
                else                           r_starve <= '0;
            end
            if (w_grant)                             r_tmo <= '0;
            else if (r_state == ST_WAIT && !w_done)  r_tmo <= r_tmo + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_q    <= '0;
            r_fdc_q    <= '0;
            r_fdc_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_fdc_done <= w_fdc_done;
            r_err      <= r_err | w_tmo | w_cpu_ovr | w_fdc_ovr;
            if (w_done && !r_mem_we) begin
                if (r_gnt_fdc) r_fdc_q <= w_rd_byte;
                else           r_cpu_q <= w_rd_byte;
            end
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] r_cpu_grants, r_fdc_grants;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_grants <= '0;
            r_fdc_grants <= '0;
        end else begin
            if (w_grant_cpu && r_cpu_grants != 16'hFFFF) r_cpu_grants <= r_cpu_grants + 16'd1;
            if (w_grant_fdc && r_fdc_grants != 16'hFFFF) r_fdc_grants <= r_fdc_grants + 16'd1;
        end
    end

    assign o_cpu_grants = r_cpu_grants;
    assign o_fdc_grants = r_fdc_grants;
`endif

    assign o_cpu_q     = r_cpu_q;
    assign o_cpu_busy  = r_cpu_busy;
    assign o_fdc_q     = r_fdc_q;
    assign o_fdc_done  = r_fdc_done;
    assign o_fdc_busy  = r_fdc_busy;
    assign o_mem_req   = r_mem_req;
    assign o_mem_a     = r_mem_a;
    assign o_mem_ds    = r_mem_ds;
    assign o_mem_we    = r_mem_we;
    assign o_mem_d     = r_mem_d;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed requests, a toggle-handshake memory model and a grant scoreboard.
module tb_sdram_port_arb;

    localparam logic [23:0] CPU_BASE = 24'h000000;
    localparam logic [23:0] FDC_BASE = 24'h010000;
    localparam logic [1:0]  ST_SYNC  = 2'd0;
    localparam logic [1:0]  ST_IDLE  = 2'd1;
    localparam logic [1:0]  ST_WAIT  = 2'd2;
    localparam int          LAT      = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_req_drv, auto_strobe, cpu_we, fdc_req, fdc_we;
    logic [15:0] cpu_a, fdc_a, mem_d, mem_q;
    logic [7:0]  cpu_d, fdc_d, cpu_q, fdc_q;
    logic        cpu_busy, fdc_busy, fdc_done, mem_req, mem_ack, mem_we, err;
    logic [23:0] mem_a;
    logic [1:0]  mem_ds, dbg_state;
`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] cpu_grants, fdc_grants;
`endif

    assign cpu_req = cpu_req_drv | auto_strobe;

    sdram_port_arb dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_a(cpu_a), .i_cpu_d(cpu_d),
        .o_cpu_q(cpu_q), .o_cpu_busy(cpu_busy),
        .i_fdc_req(fdc_req), .i_fdc_we(fdc_we), .i_fdc_a(fdc_a), .i_fdc_d(fdc_d),
        .o_fdc_q(fdc_q), .o_fdc_done(fdc_done), .o_fdc_busy(fdc_busy),
        .o_mem_req(mem_req), .i_mem_ack(mem_ack), .o_mem_a(mem_a), .o_mem_ds(mem_ds),
        .o_mem_we(mem_we), .o_mem_d(mem_d), .i_mem_q(mem_q), .o_err(err),
`ifdef SDRAM_ARB_STATS_EN
        .o_cpu_grants(cpu_grants), .o_fdc_grants(fdc_grants),
`endif
        .o_dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int n_toggles = 0;
    int fdc_pulses = 0;
    logic [42:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic we, input logic [1:0] ds, input logic [23:0] a, input logic [15:0] d);
        exp_q.push_back({we, ds, a, d});
    endtask

    // ---------------- memory model ----------------
    logic [15:0] mem_m [logic [23:0]];
    logic        m_hold = 1'b0;
    int          auto_target = 0;
    int          auto_done = 0;

    initial begin
        logic        m_pend, m_we, m_tgt;
        logic [1:0]  m_ds;
        logic [23:0] m_a;
        logic [15:0] m_d, w;
        int          m_cnt;
        m_pend = 1'b0; m_we = 1'b0; m_tgt = 1'b0; m_ds = 2'b11; m_a = '0; m_d = '0; m_cnt = 0;
        mem_ack = 1'b0;
        mem_q = '0;
        auto_strobe = 1'b0;
        mem_m[FDC_BASE + 24'd8] = 16'h3C7E;
        forever begin
            @(posedge clk);
            #1;
            auto_strobe = 1'b0;
            if (!m_pend && mem_req != mem_ack) begin
                m_pend = 1'b1; m_cnt = LAT; m_tgt = mem_req;
                m_a = mem_a; m_we = mem_we; m_ds = mem_ds; m_d = mem_d;
                if (m_we) begin
                    w = mem_m.exists(m_a) ? mem_m[m_a] : 16'h0000;
                    if (m_ds[1]) w[15:8] = m_d[15:8];
                    if (m_ds[0]) w[7:0]  = m_d[7:0];
                    mem_m[m_a] = w;
                end
            end else if (m_pend && !m_hold) begin
                if (m_cnt == 0) begin
                    mem_q   = mem_m.exists(m_a) ? mem_m[m_a] : 16'h0000;
                    mem_ack = m_tgt;
                    m_pend  = 1'b0;
                    if (auto_done < auto_target && m_a < FDC_BASE) begin
                        auto_strobe = 1'b1;
                        auto_done++;
                    end
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        last_req, prev_done;
        logic [42:0] last_bus, cur, e;
        last_req = 1'b0; prev_done = 1'b0; last_bus = '0;
        forever begin
            @(negedge clk);
            cur = {mem_we, mem_ds, mem_a, mem_d};
            if (!rst && mem_req != last_req) begin
                n_toggles++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got we=%b ds=%b a=%h d=%h, no grant expected",
                             mem_we, mem_ds, mem_a, mem_d);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_we !== e[42] || mem_ds !== e[41:40] || mem_a !== e[39:16] ||
                        (e[42] && mem_d !== e[15:0])) begin
                        errors++;
                        $display("FAIL grant: got we=%b ds=%b a=%h d=%h expected we=%b ds=%b a=%h d=%h",
                                 mem_we, mem_ds, mem_a, mem_d, e[42], e[41:40], e[39:16], e[15:0]);
                    end
                end
            end else if (!rst) begin
                checks++;
                if (cur !== last_bus) begin
                    errors++;
                    $display("FAIL mem_stable: got %h expected %h", cur, last_bus);
                end
            end
            if (fdc_done) begin
                fdc_pulses++;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL fdc_done_width: got 2+ cycles expected 1");
                end
            end
            prev_done = fdc_done;
            last_req  = mem_req;
            last_bus  = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_we = we; cpu_a = a; cpu_d = d; cpu_req_drv = 1'b1;
        @(negedge clk);
        cpu_req_drv = 1'b0;
    endtask

    task automatic fdc_op(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        fdc_we = we; fdc_a = a; fdc_d = d; fdc_req = 1'b1;
        @(negedge clk);
        fdc_req = 1'b0;
    endtask

    task automatic wait_cpu_free(input int max, input string name);
        int n = 0;
        while (cpu_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, cpu_busy}, 32'd0);
    endtask

    task automatic wait_fdc_done(input int max, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fdc_done && n < max);
        chk(name, {31'd0, fdc_done}, 32'd1);
    endtask

    task automatic wait_state(input logic [1:0] st, input int max, input string name);
        int n = 0;
        while (dbg_state != st && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, {30'd0, dbg_state}, {30'd0, st});
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_mem_req"},  {31'd0, mem_req}, 32'd0);
        chk({p, "_mem_a"},    {8'd0, mem_a},    32'd0);
        chk({p, "_mem_ds"},   {30'd0, mem_ds},  32'd3);
        chk({p, "_mem_we"},   {31'd0, mem_we},  32'd0);
        chk({p, "_mem_d"},    {16'd0, mem_d},   32'd0);
        chk({p, "_cpu_q"},    {24'd0, cpu_q},   32'd0);
        chk({p, "_fdc_q"},    {24'd0, fdc_q},   32'd0);
        chk({p, "_fdc_done"}, {31'd0, fdc_done}, 32'd0);
        chk({p, "_cpu_busy"}, {31'd0, cpu_busy}, 32'd0);
        chk({p, "_fdc_busy"}, {31'd0, fdc_busy}, 32'd0);
        chk({p, "_err"},      {31'd0, err},     32'd0);
        chk({p, "_state"},    {30'd0, dbg_state}, {30'd0, ST_SYNC});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        cpu_req_drv = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
        fdc_req = 1'b0; fdc_we = 1'b0; fdc_a = '0; fdc_d = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;
        wait_state(ST_IDLE, 20, "rst0_to_idle");

        // CPU write then read of byte 0x1235 (odd lane -> high byte of word 0x091A)
        t0 = n_toggles;
        exp_push(1'b1, 2'b10, CPU_BASE + 24'h00091A, 16'hA5A5);
        cpu_op(1'b1, 16'h1235, 8'hA5);
        #1 chk("t1_no_early_grant", n_toggles - t0, 32'd0);
        @(negedge clk);
        #1 chk("t1_grant_latency", n_toggles - t0, 32'd1);
        wait_cpu_free(50, "t1_wr_done");
        exp_push(1'b0, 2'b11, CPU_BASE + 24'h00091A, 16'h0000);
        cpu_op(1'b0, 16'h1235, 8'h00);
        wait_cpu_free(50, "t1_rd_done");
        chk("t1_cpu_q", {24'd0, cpu_q}, 32'h0000_00A5);

        // FDC read, even lane
        exp_push(1'b0, 2'b11, FDC_BASE + 24'd8, 16'h0000);
        fdc_op(1'b0, 16'h0010, 8'h00);
        wait_fdc_done(50, "t2_fdc_done");
        chk("t2_fdc_q", {24'd0, fdc_q}, 32'h0000_007E);
        @(negedge clk);
        chk("t2_fdc_busy", {31'd0, fdc_busy}, 32'd0);

        // Starvation guard: CPU re-strobes on every completion, one FDC write queued
        t0 = n_toggles;
        repeat (4) exp_push(1'b1, 2'b01, CPU_BASE + 24'h000080, 16'h1111);
        exp_push(1'b1, 2'b10, FDC_BASE + 24'h000001, 16'h5A5A);
        repeat (2) exp_push(1'b1, 2'b01, CPU_BASE + 24'h000080, 16'h1111);
        auto_target = auto_done + 5;
        @(negedge clk);
        cpu_we = 1'b1; cpu_a = 16'h0100; cpu_d = 8'h11; cpu_req_drv = 1'b1;
        fdc_we = 1'b1; fdc_a = 16'h0003; fdc_d = 8'h5A; fdc_req = 1'b1;
        @(negedge clk);
        cpu_req_drv = 1'b0; fdc_req = 1'b0;
        for (int n = 0; n < 300 && (cpu_busy || fdc_busy); n++) @(negedge clk);
        chk("t3_all_idle", {30'd0, cpu_busy, fdc_busy}, 32'd0);
        chk("t3_grant_count", n_toggles - t0, 32'd7);
        chk("t3_queue_empty", exp_q.size(), 32'd0);
        chk("t3_no_err", {31'd0, err}, 32'd0);

        // Overrun: second strobe while busy is dropped
        t0 = n_toggles;
        exp_push(1'b1, 2'b01, CPU_BASE + 24'h000100, 16'h3333);
        cpu_op(1'b1, 16'h0200, 8'h33);
        cpu_op(1'b1, 16'h0202, 8'h44);
        wait_cpu_free(50, "t4_done");
        repeat (5) @(negedge clk);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_one_toggle", n_toggles - t0, 32'd1);
        chk("t4_queue_empty", exp_q.size(), 32'd0);

        // Reset between tests clears the sticky error
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst1");
        rst = 1'b0;
        wait_state(ST_IDLE, 30, "rst1_to_idle");

        // Timeout: model never acks, then queued FDC read is served after the late ack
        m_hold = 1'b1;
        t0 = n_toggles;
        exp_push(1'b0, 2'b11, CPU_BASE + 24'h000100, 16'h0000);
        cpu_op(1'b0, 16'h0201, 8'h00);
        chk("t5_err_before", {31'd0, err}, 32'd0);
        wait_cpu_free(400, "t5_timeout_done");
        chk("t5_cpu_q_ff", {24'd0, cpu_q}, 32'h0000_00FF);
        chk("t5_err", {31'd0, err}, 32'd1);
        exp_push(1'b0, 2'b11, FDC_BASE + 24'd8, 16'h0000);
        fdc_op(1'b0, 16'h0010, 8'h00);
        repeat (20) @(negedge clk);
        chk("t5_sync_hold", {30'd0, dbg_state}, {30'd0, ST_SYNC});
        chk("t5_no_grant", n_toggles - t0, 32'd1);
        chk("t5_fdc_pending", {31'd0, fdc_busy}, 32'd1);
        m_hold = 1'b0;
        wait_fdc_done(50, "t5_fdc_done");
        chk("t5_fdc_q", {24'd0, fdc_q}, 32'h0000_007E);

        exp_push(1'b0, 2'b11, CPU_BASE + 24'h00091A, 16'h0000);
        cpu_op(1'b0, 16'h1235, 8'h00);
        wait_cpu_free(50, "t5b_rd_done");
        chk("t5b_cpu_q", {24'd0, cpu_q}, 32'h0000_00A5);

        // Reset during WAIT with the ack still owed
        m_hold = 1'b1;
        exp_push(1'b0, 2'b11, CPU_BASE + 24'h00091A, 16'h0000);
        cpu_op(1'b0, 16'h1234, 8'h00);
        repeat (5) @(negedge clk);
        chk("t6_in_wait", {30'd0, dbg_state}, {30'd0, ST_WAIT});
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst2");
        rst = 1'b0;
        t0 = n_toggles;
        exp_push(1'b1, 2'b01, CPU_BASE + 24'h000180, 16'h7777);
        cpu_op(1'b1, 16'h0300, 8'h77);
        repeat (10) @(negedge clk);
        chk("t6_no_grant", n_toggles - t0, 32'd0);
        chk("t6_sync_hold", {30'd0, dbg_state}, {30'd0, ST_SYNC});
        chk("t6_cpu_pending", {31'd0, cpu_busy}, 32'd1);
        m_hold = 1'b0;
        wait_cpu_free(50, "t6_done");
        chk("t6_grant_count", n_toggles - t0, 32'd1);
        chk("t6_err", {31'd0, err}, 32'd0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_fdc_pulses", fdc_pulses, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
